// File: rtl/wb_fifo_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo_responder_if
// Brief    : Wishbone bus bundle between a master and wb_fifo_responder.
// Revision : 1.0
// ============================================================================
interface wb_fifo_responder_if #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 16
);
    logic                         cyc;
    logic                         stb;
    logic [WB_ADDR_WIDTH-1:0]     adr;
    logic                         we;
    logic [WB_DATA_WIDTH-1:0]     dout;
    logic [WB_DATA_WIDTH/8-1:0]   sel;
    logic [WB_DATA_WIDTH-1:0]     din;
    logic                         ack;
    logic                         err;
    logic                         rty;
    logic                         inta;

    modport master (
        output cyc, stb, adr, we, dout, sel,
        input  din, ack, err, rty, inta
    );

    modport slave (
        input  cyc, stb, adr, we, dout, sel,
        output din, ack, err, rty, inta
    );
endinterface
`default_nettype wire

// File: rtl/wb_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo_responder
// Brief    : Wishbone slave bridging TXDATA writes to a TX stream and an RX
//            stream to RXDATA reads, with status and a level interrupt.
// Revision : 1.0
// ============================================================================
module wb_fifo_responder #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int WAIT_STATES   = 1
) (
    input  wire                      clk,
    input  wire                      rst_n,
    wb_fifo_responder_if.slave       bus,
    output logic [WB_DATA_WIDTH-1:0] tx_data_o,
    output logic                     tx_valid_o,
    input  wire                      tx_ready_i,
    input  wire  [WB_DATA_WIDTH-1:0] rx_data_i,
    input  wire                      rx_valid_i,
    output logic                     rx_ready_o
);
    localparam int         C_SW      = WB_DATA_WIDTH / 8;
    localparam int         C_PW      = $clog2(FIFO_DEPTH);
    localparam int         C_CW      = C_PW + 1;
    localparam logic [3:0] C_WS_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                     state_q;
    logic [3:0]                 wcnt_q;
    logic [WB_ADDR_WIDTH-1:0]   adr_q;
    logic                       we_q;
    logic [WB_DATA_WIDTH-1:0]   dout_q;
    logic [C_SW-1:0]            sel_q;
    logic                       ack_q, err_q, rty_q, inta_q, rdy_q;
    logic [WB_DATA_WIDTH-1:0]   din_q;
    logic [1:0]                 irq_en_q;

    logic [WB_DATA_WIDTH-1:0]   tx_mem_q [FIFO_DEPTH];
    logic [WB_DATA_WIDTH-1:0]   rx_mem_q [FIFO_DEPTH];
    logic [C_PW-1:0]            tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [C_CW-1:0]            tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    logic [WB_ADDR_WIDTH-1:0]   req_adr;
    logic                       req_we;
    logic [WB_DATA_WIDTH-1:0]   req_dout;
    logic [C_SW-1:0]            req_sel;
    logic [3:0]                 req_idx;
    logic                       req_hi;
    logic                       dec_err, dec_rty;
    logic                       resp_go, commit;
    logic                       tx_push, tx_pop, rx_push, rx_pop, irq_wr;
    logic                       tx_empty, tx_full, rx_empty, rx_full;
    logic [WB_DATA_WIDTH-1:0]   status, rd_data;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == C_CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == C_CW'(FIFO_DEPTH));

    // With zero wait states the decision is taken straight from the bus in IDLE.
    always_comb begin
        req_adr  = adr_q;
        req_we   = we_q;
        req_dout = dout_q;
        req_sel  = sel_q;
        if (state_q == S_IDLE) begin
            req_adr  = bus.adr;
            req_we   = bus.we;
            req_dout = bus.dout;
            req_sel  = bus.sel;
        end
    end

    assign req_idx = req_adr[3:0];
    assign req_hi  = |req_adr[WB_ADDR_WIDTH-1:4];

    always_comb begin
        dec_err = 1'b0;
        dec_rty = 1'b0;
        if (req_hi || (req_idx > 4'd3)) begin
            dec_err = 1'b1;
        end else begin
            case (req_idx)
                4'd0: begin
                    if (!req_we || (req_sel != '1)) dec_err = 1'b1;
                    else                            dec_rty = tx_full;
                end
                4'd1: begin
                    if (req_we) dec_err = 1'b1;
                    else        dec_rty = rx_empty;
                end
                4'd2:    dec_err = req_we;
                default: ;
            endcase
        end
    end

    always_comb begin
        status                    = '0;
        status[0]                 = tx_empty;
        status[1]                 = tx_full;
        status[2]                 = rx_empty;
        status[3]                 = rx_full;
        status[4 +: C_CW]         = tx_cnt_q;
        status[4 + C_CW +: C_CW]  = rx_cnt_q;
    end

    always_comb begin
        rd_data = '0;
        case (req_idx)
            4'd1:    rd_data      = rx_mem_q[rx_rd_q];
            4'd2:    rd_data      = status;
            4'd3:    rd_data[1:0] = irq_en_q;
            default: ;
        endcase
    end

    assign resp_go = ((state_q == S_IDLE) && bus.cyc && bus.stb && (WAIT_STATES == 0)) ||
                     ((state_q == S_WAIT) && bus.cyc && (wcnt_q == C_WS_LAST));
    assign commit  = resp_go && !dec_err && !dec_rty;
    assign tx_push = commit && req_we && (req_idx == 4'd0);
    assign rx_pop  = commit && !req_we && (req_idx == 4'd1);
    assign irq_wr  = commit && req_we && (req_idx == 4'd3) && req_sel[0];
    assign tx_pop  = !tx_empty && tx_ready_i;
    assign rx_push = rx_valid_i && rx_ready_o;

    assign tx_cnt_d = tx_cnt_q + C_CW'(tx_push) - C_CW'(tx_pop);
    assign rx_cnt_d = rx_cnt_q + C_CW'(rx_push) - C_CW'(rx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= req_dout;
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // Terminations are set on RESP entry so they are high exactly while in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            adr_q    <= '0;
            we_q     <= 1'b0;
            dout_q   <= '0;
            sel_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rty_q    <= 1'b0;
            din_q    <= '0;
            irq_en_q <= '0;
            inta_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rty_q  <= 1'b0;
            din_q  <= '0;
            rdy_q  <= 1'b1;
            inta_q <= (irq_en_q[0] && !rx_empty) || (irq_en_q[1] && tx_empty);
            if (irq_wr) irq_en_q <= req_dout[1:0];
            case (state_q)
                S_IDLE: begin
                    if (bus.cyc && bus.stb) begin
                        adr_q   <= bus.adr;
                        we_q    <= bus.we;
                        dout_q  <= bus.dout;
                        sel_q   <= bus.sel;
                        wcnt_q  <= '0;
                        state_q <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.cyc)                  state_q <= S_IDLE;
                    else if (wcnt_q == C_WS_LAST)  state_q <= S_RESP;
                    else                           wcnt_q  <= wcnt_q + 4'd1;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            if (resp_go) begin
                ack_q <= !dec_err && !dec_rty;
                err_q <= dec_err;
                rty_q <= !dec_err && dec_rty;
                if (commit && !req_we) din_q <= rd_data;
            end
        end
    end

    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
    assign bus.rty    = rty_q;
    assign bus.din    = din_q;
    assign bus.inta   = inta_q;
    assign tx_data_o  = tx_mem_q[tx_rd_q];
    assign tx_valid_o = !tx_empty;
    assign rx_ready_o = rdy_q && !rx_full;
endmodule
`default_nettype wire
